// File: rtl/alu_mem_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_mem_exec_unit
//
// Execute/memory slice of a single-cycle MIPS datapath. Holds the ALU control
// decoder, the 32-bit ALU and a word-addressed data memory. The ALU result is
// both the datapath result and the memory address.
//
// Ports:
//   clk          in   1   system clock; memory writes on the rising edge
//   rst          in   1   asynchronous active-high reset (clears memory)
//   alu_op       in   2   ALUOp from main control
//   func_code    in   6   instruction bits [5:0]
//   a            in  32   ALU operand A (rs)
//   b            in  32   ALU operand B (ALUSrc mux output)
//   write_data   in  32   store data (rt)
//   mem_read     in   1   enables read_data
//   mem_write    in   1   enables the memory write
//   alu_ctrl_out out  4   decoded ALU operation
//   alu_out      out 32   ALU result / memory address
//   zero         out  1   alu_out == 0
//   read_data    out 32   memory read data (0 when not reading)
// ---------------------------------------------------------------------------
module alu_mem_exec_unit #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  func_code,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [3:0]  alu_ctrl_out,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] read_data
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] word_index;

    // ALU control decode
    always_comb begin
        alu_ctrl_out = OP_ADD;
        case (alu_op)
            2'b00: alu_ctrl_out = OP_ADD;
            2'b01: alu_ctrl_out = OP_SUB;
            2'b10: begin
                case (func_code)
                    FN_ADD:  alu_ctrl_out = OP_ADD;
                    FN_SUB:  alu_ctrl_out = OP_SUB;
                    FN_AND:  alu_ctrl_out = OP_AND;
                    FN_OR:   alu_ctrl_out = OP_OR;
                    FN_NOR:  alu_ctrl_out = OP_NOR;
                    FN_SLT:  alu_ctrl_out = OP_SLT;
                    default: alu_ctrl_out = OP_ADD;
                endcase
            end
            default: alu_ctrl_out = OP_ADD;
        endcase
    end

    // ALU: add/sub wrap modulo 2^32, no overflow detection
    always_comb begin
        alu_out = 32'h0;
        case (alu_ctrl_out)
            OP_AND:  alu_out = a & b;
            OP_OR:   alu_out = a | b;
            OP_ADD:  alu_out = a + b;
            OP_SUB:  alu_out = a - b;
            OP_SLT:  alu_out = {31'h0, ($signed(a) < $signed(b))};
            OP_NOR:  alu_out = ~(a | b);
            default: alu_out = 32'h0;
        endcase
    end

    assign zero = (alu_out == 32'h0);

    // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH.
    assign word_index = alu_out[ADDR_W-1:0];

    // Reset clears the whole array at once, which also drops any write that
    // would have landed on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write) begin
            mem[word_index] <= write_data;
        end
    end

    // Combinational read: a same-address write shows up only after the edge.
    always_comb begin
        read_data = 32'h0;
        if (mem_read && !rst) begin
            read_data = mem[word_index];
        end
    end

endmodule

// File: tb/tb_alu_mem_exec_unit.sv
module tb_alu_mem_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alu_op;
    logic [5:0]  func_code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_ctrl_out;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    alu_mem_exec_unit #(.MEM_DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .alu_op(alu_op),
        .func_code(func_code),
        .a(a),
        .b(b),
        .write_data(write_data),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .alu_ctrl_out(alu_ctrl_out),
        .alu_out(alu_out),
        .zero(zero),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [5:0] fn_tab  [7];
    logic [3:0] ctl_tab [7];

    initial begin
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
        ctl_tab = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100,   4'b0111,   4'b0010};

        rst = 1'b1;
        alu_op = 2'b00;
        func_code = 6'h0;
        a = 32'h0;
        b = 32'h0;
        write_data = 32'h0;
        mem_read = 1'b1;
        mem_write = 1'b0;
        #1;
        chk("reset_read_data", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_read = 1'b0;

        // decode sweep
        alu_op = 2'b00; #1;
        chk("dec_op00", {28'h0, alu_ctrl_out}, 32'h2);
        alu_op = 2'b01; #1;
        chk("dec_op01", {28'h0, alu_ctrl_out}, 32'h6);
        alu_op = 2'b11; #1;
        chk("dec_op11", {28'h0, alu_ctrl_out}, 32'h2);
        alu_op = 2'b10;
        for (int i = 0; i < 7; i++) begin
            func_code = fn_tab[i]; #1;
            chk($sformatf("dec_func_%b", fn_tab[i]), {28'h0, alu_ctrl_out}, {28'h0, ctl_tab[i]});
        end

        // arithmetic
        func_code = 6'b100000; a = 32'd5; b = 32'd7; #1;
        chk("add_5_7", alu_out, 32'd12);
        chk("add_5_7_zero", {31'h0, zero}, 32'h0);
        func_code = 6'b100010; a = 32'd9; b = 32'd9; #1;
        chk("sub_9_9", alu_out, 32'h0);
        chk("sub_9_9_zero", {31'h0, zero}, 32'h1);
        func_code = 6'b100000; a = 32'hFFFFFFFF; b = 32'd1; #1;
        chk("add_wrap", alu_out, 32'h0);
        chk("add_wrap_zero", {31'h0, zero}, 32'h1);
        alu_op = 2'b01; a = 32'd3; b = 32'd10; #1;
        chk("beq_sub_neg", alu_out, 32'hFFFFFFF9);

        // logic / slt
        alu_op = 2'b10; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
        func_code = 6'b100100; #1;
        chk("and", alu_out, 32'h00F000F0);
        func_code = 6'b100101; #1;
        chk("or", alu_out, 32'hFFF0FFF0);
        func_code = 6'b100111; #1;
        chk("nor", alu_out, 32'h000F000F);
        func_code = 6'b101010; a = 32'hFFFFFFFF; b = 32'd1; #1;
        chk("slt_neg1_1", alu_out, 32'd1);
        a = 32'd1; b = 32'hFFFFFFFF; #1;
        chk("slt_1_neg1", alu_out, 32'd0);
        chk("slt_1_neg1_zero", {31'h0, zero}, 32'h1);

        // store / load at address 3
        @(negedge clk);
        alu_op = 2'b00; a = 32'd2; b = 32'd1;
        mem_write = 1'b1; write_data = 32'hDEADBEEF; mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; #1;
        chk("load_addr3", read_data, 32'hDEADBEEF);
        mem_read = 1'b0; #1;
        chk("load_disabled", read_data, 32'h0);

        // address wrap: 3 + 64 lands on word 3
        a = 32'd67; b = 32'd0; mem_write = 1'b1; write_data = 32'h00001234;
        @(posedge clk); #1;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; a = 32'd3; #1;
        chk("wrap_read_addr3", read_data, 32'h00001234);

        // same-cycle read and write
        mem_write = 1'b1; write_data = 32'h00005555; #1;
        chk("rw_before_edge", read_data, 32'h00001234);
        @(posedge clk); #1;
        chk("rw_after_edge", read_data, 32'h00005555);

        // fill another word, then pulse reset between edges
        @(negedge clk);
        a = 32'd10; write_data = 32'h0000AAAA;
        @(posedge clk); #1;
        @(negedge clk);
        mem_write = 1'b0; #1;
        chk("fill_addr10", read_data, 32'h0000AAAA);
        rst = 1'b1; #1;
        chk("rst_read_addr10", read_data, 32'h0);
        chk("rst_alu_comb", alu_out, 32'd10);
        rst = 1'b0; #1;
        chk("post_rst_addr10", read_data, 32'h0);
        a = 32'd3; #1;
        chk("post_rst_addr3", read_data, 32'h0);
        for (int i = 0; i < 64; i += 9) begin
            a = i; #1;
            chk($sformatf("post_rst_sweep_%0d", i), read_data, 32'h0);
        end

        // write attempted while reset is held
        @(negedge clk);
        rst = 1'b1; a = 32'd5; mem_write = 1'b1; write_data = 32'h0000FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0; #1;
        chk("write_in_rst_ignored", read_data, 32'h0);

        // memory still functional after reset
        mem_write = 1'b1; write_data = 32'h0BADF00D;
        @(posedge clk); #1;
        mem_write = 1'b0; #1;
        chk("write_after_rst", read_data, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mem_exec_unit.md
Name: alu_mem_exec_unit

Overview:
Execute/memory slice of the single-cycle MIPS datapath. It contains three parts:
- ALU control decoder: turns the 2-bit ALUOp and the 6-bit function code into a 4-bit ALU operation.
- 32-bit ALU: produces a result and a zero flag.
- Word-addressed data memory: addressed by the ALU result, written with the rt operand, read back for the MemtoReg mux.
Sits between the register file / ALUSrc mux and the MemtoReg mux.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in data memory (power of two).
- ADDR_W, 6, log2(MEM_DEPTH); width of the word index taken from alu_out.

Ports:
- clk  input  1  system clock; memory writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_op  input  2  ALUOp from main control.
- func_code  input  6  instruction bits [5:0].
- a  input  32  ALU operand A (rs content).
- b  input  32  ALU operand B (ALUSrc mux output).
- write_data  input  32  store data (rt content).
- mem_read  input  1  enables read_data.
- mem_write  input  1  enables the memory write.
- alu_ctrl_out  output  4  decoded ALU operation.
- alu_out  output  32  ALU result; also the memory address.
- zero  output  1  1 when alu_out == 0.
- read_data  output  32  memory read data.

Behaviour:
One clock; reset is asynchronous and active-high.

ALU control (combinational):
- alu_op 00 -> 0010 (add, lw/sw).
- alu_op 01 -> 0110 (sub, beq).
- alu_op 10 -> decode func_code:
  - 100000 -> 0010 add
  - 100010 -> 0110 sub
  - 100100 -> 0000 and
  - 100101 -> 0001 or
  - 100111 -> 1100 nor
  - 101010 -> 0111 slt
  - any other code -> 0010
- alu_op 11 -> 0010.

ALU (combinational, driven by alu_ctrl_out):
- 0000: a & b
- 0001: a | b
- 0010: a + b, modulo 2^32, no overflow flag or trap
- 0110: a - b, modulo 2^32
- 0111: 1 if $signed(a) < $signed(b), else 0; zero-extended to 32 bits
- 1100: ~(a | b)
- Any other code: 0.
- zero = (alu_out == 32'h0), recomputed combinationally.

Data memory:
- MEM_DEPTH x 32 register array. Word index = alu_out[ADDR_W-1:0]; upper address bits are ignored, so addresses wrap modulo MEM_DEPTH.
- Write: on the rising clk edge when mem_write=1 and rst=0, mem[index] <= write_data.
- Read: combinational. read_data = mem[index] when mem_read=1, otherwise 32'h0.
- Simultaneous mem_read and mem_write to the same index: read_data shows the old word until the edge and the new word immediately after it.
- rst=1 (asynchronous) clears every memory word to 0 immediately. While rst is high, writes are ignored and reads return 0.
- Reset asserted mid-operation aborts any pending write; no partial update.

Outputs at reset:
- read_data = 0.
- alu_ctrl_out, alu_out and zero remain purely combinational functions of the inputs; they are not affected by rst.

Latency:
- All outputs are zero-cycle combinational.
- Stored data is visible one edge after a write.

Test Plan:
- Decode sweep: alu_op=00 -> 0010; alu_op=01 -> 0110; alu_op=10 with func 100000/100010/100100/100101/100111/101010 -> 0010/0110/0000/0001/1100/0111; alu_op=10 with func 000000 -> 0010.
- Arithmetic:
  - add a=5, b=7 -> alu_out=12, zero=0.
  - sub a=9, b=9 -> alu_out=0, zero=1.
  - add 32'hFFFFFFFF + 1 -> 0, zero=1 (wrap).
- Logic/slt:
  - a=32'hF0F0F0F0, b=32'h0FF00FF0: and -> 32'h00F000F0, or -> 32'hFFF0FFF0, nor -> 32'h000F000F.
  - slt a=32'hFFFFFFFF (-1), b=1 -> 1.
  - slt a=1, b=-1 -> 0.
- Store/load:
  - alu_op=00, a=2, b=1 -> address 3; mem_write=1, write_data=32'hDEADBEEF; clock one edge.
  - Then mem_write=0, mem_read=1 -> read_data=32'hDEADBEEF.
  - mem_read=0 -> read_data=0.
- Wrap and same-cycle:
  - Write 32'h1234 at address 3+MEM_DEPTH; reading address 3 returns 32'h1234.
  - With mem_read=1 and mem_write=1 of 32'h5555 to the same address, read_data is the old value before the edge and 32'h5555 after it.
- Async reset:
  - After filling words, pulse rst between clock edges -> read_data=0 immediately for every address.
  - A write attempted while rst=1 leaves the word at 0.
